// File: rtl/axil_cmd_queue.sv
// axil_cmd_queue: in-order command FIFO feeding the user port of an AXI-Lite master.
// Each queued command is launched as a one-cycle write (valid) or read (read_valid)
// start pulse, then the queue waits for the master's ready before launching the next.
// Optional feature: define AXIL_CMD_QUEUE_TIMEOUT_EN to enable a watchdog on the WAIT
// state. When it fires, the stuck command is dropped and the sticky timeout_err is set.
module axil_cmd_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [31:0]            cmd_addr,
    input  logic [31:0]            cmd_data,
    input  logic [3:0]             cmd_strb,
    output logic                   valid,
    output logic                   read_valid,
    output logic [31:0]            aw_addr,
    output logic [31:0]            w_data,
    output logic [3:0]             w_strb,
    output logic [31:0]            ar_addr,
    input  logic                   ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   timeout_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Stored command payload.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Elaboration-time parameter checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axil_cmd_queue: DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("axil_cmd_queue: TIMEOUT_CYC must be at least 1");
    end

    // FIFO storage and bookkeeping.
    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    cmd_t             cmd_in_c;
    cmd_t             head_c;
    logic             push_c;
    logic             pop_c;
    logic             cmd_ready_c;

    // Controller state and registered user-port outputs.
    state_t           state_q;
    logic             valid_q;
    logic             read_valid_q;
    logic [31:0]      aw_addr_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic [31:0]      ar_addr_q;

`ifdef AXIL_CMD_QUEUE_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             timeout_err_q;
`endif

    // Pack the producer's command into the storage format.
    always_comb begin
        cmd_in_c       = '0;
        cmd_in_c.write = cmd_write;
        cmd_in_c.addr  = cmd_addr;
        cmd_in_c.data  = cmd_data;
        cmd_in_c.strb  = cmd_strb;
    end

    // Accept only from registered occupancy; a full queue never takes a same-cycle bypass.
    assign cmd_ready_c = (count_q < CNT_W'(DEPTH));
    assign push_c      = cmd_valid & cmd_ready_c;
    assign head_c      = mem_q[rd_ptr_q];
    assign pop_c       = (state_q == ST_IDLE) && (count_q != '0);

    // Next pointer / occupancy values; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge ACLK) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    // Issue controller: IDLE pops and loads the port fields, ISSUE pulses for one cycle,
    // WAIT holds until ready (or the watchdog expires when enabled).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= ST_IDLE;
            valid_q       <= 1'b0;
            read_valid_q  <= 1'b0;
            aw_addr_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            ar_addr_q     <= '0;
`ifdef AXIL_CMD_QUEUE_TIMEOUT_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            read_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        state_q <= ST_ISSUE;
                        if (head_c.write) begin
                            valid_q   <= 1'b1;
                            aw_addr_q <= head_c.addr;
                            w_data_q  <= head_c.data;
                            w_strb_q  <= head_c.strb;
                        end else begin
                            read_valid_q <= 1'b1;
                            ar_addr_q    <= head_c.addr;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A completion already visible during the pulse cycle is honoured.
                    state_q <= ready ? ST_IDLE : ST_WAIT;
`ifdef AXIL_CMD_QUEUE_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    if (ready) begin
                        state_q <= ST_IDLE;
`ifdef AXIL_CMD_QUEUE_TIMEOUT_EN
                    end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        // Give up on the stuck transaction and flag it until reset.
                        state_q       <= ST_IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output drive.
    assign cmd_ready  = cmd_ready_c;
    assign valid      = valid_q;
    assign read_valid = read_valid_q;
    assign aw_addr    = aw_addr_q;
    assign w_data     = w_data_q;
    assign w_strb     = w_strb_q;
    assign ar_addr    = ar_addr_q;
    assign busy       = (state_q != ST_IDLE) || (count_q != '0);
    assign q_count    = count_q;
`ifdef AXIL_CMD_QUEUE_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

`ifndef SYNTHESIS
    // Simulation sanity: the two start pulses are exclusive and occupancy never overflows.
    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            assert (!(valid_q && read_valid_q))
                else $error("axil_cmd_queue: write and read start pulses asserted together");
            assert (count_q <= CNT_W'(DEPTH))
                else $error("axil_cmd_queue: occupancy exceeds DEPTH");
        end
    end
`endif

endmodule
